ecap5_wb_ram: RTL
=================

Name: ecap5_wb_ram

Overview:
- Wishbone B4 pipelined slave on-chip RAM.
- Sits directly downstream of the ecap5_dproc Wishbone master port and serves both instruction fetches and load/store traffic.
- Fixed, parameterised response latency; bounded outstanding requests, backpressured through wb_stall_o.
- Used as the system/test memory behind the processor.

Parameters:
- DEPTH_LOG2, 12, log2 of RAM depth in 32-bit words (default 16 KiB).
- LATENCY, 2, cycles from request acceptance to wb_ack_o; legal 1..8.
- MAX_OUTSTANDING, 2, maximum accepted-but-unacknowledged requests; legal 1..LATENCY.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- wb_adr_i  in  32  byte address; bits [DEPTH_LOG2+1:2] select the word, others ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid while wb_ack_o=1.
- wb_sel_i  in  4  byte-lane enables; bit n covers bits [8n+7:8n].
- wb_we_i  in  1  1=write, 0=read.
- wb_stb_i  in  1  request strobe.
- wb_cyc_i  in  1  bus cycle active.
- wb_ack_o  out  1  request completion, one pulse per accepted request.
- wb_stall_o  out  1  slave cannot accept a request this cycle.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_i=0 at a rising edge):
  - wb_ack_o=0, wb_dat_o=0, wb_stall_o=0.
  - Response pipeline cleared; outstanding count=0.
  - RAM contents not cleared.
- Accept: request accepted at an edge where wb_cyc_i & wb_stb_i & !wb_stall_o.
- Write: committed to RAM at the accepting edge.
  - Only lanes with wb_sel_i[n]=1 are updated.
  - wb_sel_i=0000 writes nothing but is still acked.
- Read: word sampled at the accepting edge.
  - Observes every earlier-accepted write, including one accepted the previous cycle.
  - wb_sel_i ignored; all 32 bits returned.
- Response pipeline: LATENCY-stage shift register of {valid, we, data}, advancing every cycle.
  - Accept at edge N gives wb_ack_o=1 in the cycle after edge N+LATENCY-1; LATENCY=1 means ack in the cycle right after acceptance.
  - Ack is a single cycle.
  - wb_dat_o = read data on read acks; 0 on write acks and when wb_ack_o=0.
- Acks return in acceptance order. Back-to-back accepts give back-to-back acks.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on accept; -1 on ack; unchanged on simultaneous accept+ack.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- wb_stall_o = (count == MAX_OUTSTANDING), combinational from registered count.
  - A request presented while stalled is not accepted; the master must hold it.
  - Stall rises the cycle after the accept that fills the last slot.
  - Stall falls the cycle after the ack that frees a slot.
- wb_cyc_i low at an edge = abort:
  - All pipeline valid bits cleared; count=0; no further acks for those requests.
  - Writes already accepted remain committed.
  - wb_stb_i is ignored while wb_cyc_i=0.
- Reset mid-transaction: identical to abort, plus outputs forced to their reset values.
- Address aliasing: 0x0000_4000 with DEPTH_LOG2=12 maps to word 0.

Test Plan:
- Write 0xDEADBEEF to 0x10 (sel 1111), then read 0x10, LATENCY=2 → read ack 2 cycles after accept, wb_dat_o=0xDEADBEEF; write ack shows wb_dat_o=0.
- Init 0x20=0x11223344; write 0xAABBCCDD with sel 0101; read → 0x11BB33DD.
- LATENCY=2, MAX_OUTSTANDING=2: 4 reads of 0x0,0x4,0x8,0xC with stb held → wb_stall_o toggles so accepts/acks alternate; 4 acks in order with matching data; count returns to 0.
- LATENCY=3, MAX_OUTSTANDING=3: 3 back-to-back writes then read → stall high 1 cycle after third accept; read accepted the cycle after first ack; read data = last write.
- Issue 2 reads, drop wb_cyc_i the next cycle → no wb_ack_o for 8 cycles; stall=0; new read then acked normally after LATENCY.
- Accept a write of 0x12345678 to 0x40, assert rst_i=0 one cycle later → wb_ack_o never pulses; outputs reset; post-reset read of 0x40 returns 0x12345678.

Source files
------------

// File: rtl/ecap5_wb_ram.sv
// Wishbone B4 pipelined on-chip RAM slave: fixed response latency and
// a bounded number of outstanding requests, backpressured via wb_stall_o.
module ecap5_wb_ram #(
   parameter int unsigned DEPTH_LOG2      = 12,
   parameter int unsigned LATENCY         = 2,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic        wb_stall_o
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [31:0]           mem_q [DEPTH];
   logic [LATENCY-1:0]    vld_q, vld_d;
   logic [31:0]           dat_q [LATENCY];
   logic [31:0]           dat_d [LATENCY];
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  accept_c;
   logic                  ack_c;
   logic                  stall_c;
   logic [DEPTH_LOG2-1:0] idx_c;
   logic [31:0]           rdata_c;
   logic                  unused_adr_c;

   assign idx_c        = wb_adr_i[DEPTH_LOG2+1:2];
   assign unused_adr_c = ^{wb_adr_i[31:DEPTH_LOG2+2], wb_adr_i[1:0]};
   assign rdata_c      = mem_q[idx_c];
   assign stall_c      = (cnt_q == CNT_MAX);
   assign ack_c        = vld_q[LATENCY-1];
   assign accept_c     = wb_cyc_i & wb_stb_i & ~stall_c;

   // Response pipeline and outstanding counter; dropping cyc aborts everything in flight.
   always_comb begin
      vld_d = '0;
      for (int i = 0; i < int'(LATENCY); i++) dat_d[i] = '0;
      cnt_d = '0;
      if (wb_cyc_i) begin
         cnt_d    = cnt_q;
         vld_d[0] = accept_c;
         dat_d[0] = (accept_c && !wb_we_i) ? rdata_c : 32'h0;
         for (int i = 1; i < int'(LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
         end
         case ({accept_c, ack_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         vld_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(LATENCY); i++) dat_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         cnt_q <= cnt_d;
         for (int i = 0; i < int'(LATENCY); i++) dat_q[i] <= dat_d[i];
      end
   end

   // Storage is never cleared by reset; writes land at the accepting edge.
   always_ff @(posedge clk_i) begin
      if (rst_i && accept_c && wb_we_i) begin
         for (int n = 0; n < 4; n++) begin
            if (wb_sel_i[n]) mem_q[idx_c][8*n +: 8] <= wb_dat_i[8*n +: 8];
         end
      end
   end

   assign wb_ack_o   = ack_c;
   assign wb_dat_o   = dat_q[LATENCY-1];
   assign wb_stall_o = stall_c;

endmodule
